// File: rtl/cr16_alu_arbiter.sv
// Shares one CR16 ALU between two requesters: arbitrate, pulse the ALU enable, capture and return the result.
// Define CR16_ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins); otherwise round-robin.
module cr16_alu_arbiter #(
  parameter int P_WIDTH = 16
) (
  input  logic                 I_CLK,
  input  logic                 I_NRESET,
  input  logic [1:0]           I_REQ_VALID,
  output logic [1:0]           O_REQ_READY,
  input  logic [7:0]           I_REQ_OPCODE,
  input  logic [2*P_WIDTH-1:0] I_REQ_A,
  input  logic [2*P_WIDTH-1:0] I_REQ_B,
  output logic [1:0]           O_RSP_VALID,
  input  logic [1:0]           I_RSP_READY,
  output logic [P_WIDTH-1:0]   O_RSP_C,
  output logic [4:0]           O_RSP_STATUS,
  output logic [4:0]           O_PSR,
  output logic                 O_BUSY,
  output logic                 O_ALU_ENABLE,
  output logic [3:0]           O_ALU_OPCODE,
  output logic [P_WIDTH-1:0]   O_ALU_A,
  output logic [P_WIDTH-1:0]   O_ALU_B,
  input  logic [P_WIDTH-1:0]   I_ALU_C,
  input  logic [4:0]           I_ALU_STATUS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LP_OP_UNDEF = 4'hF;

  state_t               r_state;
  state_t               w_next;
  logic                 r_grant;
  logic [3:0]           r_opcode;
  logic [P_WIDTH-1:0]   r_a;
  logic [P_WIDTH-1:0]   r_b;
  logic [P_WIDTH-1:0]   r_rsp_c;
  logic [4:0]           r_rsp_status;
  logic [4:0]           r_psr;
  logic                 w_grant;
  logic                 w_accept;
  logic                 w_rsp_hs;
  logic [3:0]           w_op;
  logic [P_WIDTH-1:0]   w_a;
  logic [P_WIDTH-1:0]   w_b;

`ifdef CR16_ALU_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_grant = 1'b0;
    if (!I_REQ_VALID[0] && I_REQ_VALID[1]) w_grant = 1'b1;
  end
`else
  logic r_ptr;

  // The pointer names the favoured requester; the other wins only when the favoured one is idle.
  always_comb begin
    w_grant = r_ptr;
    if (!I_REQ_VALID[r_ptr] && I_REQ_VALID[~r_ptr]) w_grant = ~r_ptr;
  end
`endif

  assign w_op = w_grant ? I_REQ_OPCODE[7:4] : I_REQ_OPCODE[3:0];
  assign w_a  = w_grant ? I_REQ_A[2*P_WIDTH-1:P_WIDTH] : I_REQ_A[P_WIDTH-1:0];
  assign w_b  = w_grant ? I_REQ_B[2*P_WIDTH-1:P_WIDTH] : I_REQ_B[P_WIDTH-1:0];

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_rsp_hs     = 1'b0;
    O_REQ_READY  = 2'b00;
    O_RSP_VALID  = 2'b00;
    O_ALU_ENABLE = 1'b0;
    O_BUSY       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        O_REQ_READY = w_grant ? 2'b10 : 2'b01;
        w_accept    = I_REQ_VALID[w_grant];
        if (w_accept) w_next = (w_op == LP_OP_UNDEF) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        O_ALU_ENABLE = 1'b1;
        w_next       = S_WAIT;
      end
      S_WAIT: w_next = S_RESP;
      S_RESP: begin
        O_RSP_VALID = r_grant ? 2'b10 : 2'b01;
        w_rsp_hs    = I_RSP_READY[r_grant];
        if (w_rsp_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Undefined opcode skips the ALU entirely, so its zero response is loaded at accept.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_opcode     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_c      <= '0;
      r_rsp_status <= '0;
      r_psr        <= '0;
`ifndef CR16_ALU_ARB_FIXED_PRIORITY_EN
      r_ptr        <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant  <= w_grant;
        r_opcode <= w_op;
        r_a      <= w_a;
        r_b      <= w_b;
        if (w_op == LP_OP_UNDEF) begin
          r_rsp_c      <= '0;
          r_rsp_status <= '0;
        end
      end
      if (r_state == S_WAIT) begin
        r_rsp_c      <= I_ALU_C;
        r_rsp_status <= I_ALU_STATUS;
        r_psr        <= I_ALU_STATUS;
      end
`ifndef CR16_ALU_ARB_FIXED_PRIORITY_EN
      if (w_rsp_hs) r_ptr <= ~r_grant;
`endif
    end
  end

  assign O_RSP_C      = r_rsp_c;
  assign O_RSP_STATUS = r_rsp_status;
  assign O_PSR        = r_psr;
  assign O_ALU_OPCODE = r_opcode;
  assign O_ALU_A      = r_a;
  assign O_ALU_B      = r_b;

endmodule

// File: tb/tb_cr16_alu_arbiter.sv
// Bench for cr16_alu_arbiter: a stand-in clocked ALU, a transaction-level reference model,
// directed vectors, reset/backpressure sequences and randomized traffic.
module tb_cr16_alu_arbiter;

  localparam int W = 16;

  logic           I_CLK = 1'b0;
  logic           I_NRESET = 1'b0;
  logic [1:0]     I_REQ_VALID = '0;
  logic [1:0]     O_REQ_READY;
  logic [7:0]     I_REQ_OPCODE = '0;
  logic [2*W-1:0] I_REQ_A = '0;
  logic [2*W-1:0] I_REQ_B = '0;
  logic [1:0]     O_RSP_VALID;
  logic [1:0]     I_RSP_READY = '0;
  logic [W-1:0]   O_RSP_C;
  logic [4:0]     O_RSP_STATUS;
  logic [4:0]     O_PSR;
  logic           O_BUSY;
  logic           O_ALU_ENABLE;
  logic [3:0]     O_ALU_OPCODE;
  logic [W-1:0]   O_ALU_A;
  logic [W-1:0]   O_ALU_B;
  logic [W-1:0]   aluC = '0;
  logic [4:0]     aluSt = '0;

  int nChecks = 0;
  int nPass = 0;
  int lastGrant = 1;
  logic [4:0] modelPsr = '0;

  cr16_alu_arbiter #(.P_WIDTH(W)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET),
    .I_REQ_VALID(I_REQ_VALID), .O_REQ_READY(O_REQ_READY),
    .I_REQ_OPCODE(I_REQ_OPCODE), .I_REQ_A(I_REQ_A), .I_REQ_B(I_REQ_B),
    .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY),
    .O_RSP_C(O_RSP_C), .O_RSP_STATUS(O_RSP_STATUS), .O_PSR(O_PSR), .O_BUSY(O_BUSY),
    .O_ALU_ENABLE(O_ALU_ENABLE), .O_ALU_OPCODE(O_ALU_OPCODE),
    .O_ALU_A(O_ALU_A), .O_ALU_B(O_ALU_B),
    .I_ALU_C(aluC), .I_ALU_STATUS(aluSt)
  );

  always #5 I_CLK = ~I_CLK;

  // Returns {status, result}; status = {negative, zero, flag, low, carry}.
  function automatic logic [20:0] aluRef(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] c;
    logic carry, low, flag;
    low = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[15:0];
        carry = s[16];
        flag = (a[15] == b[15]) && (c[15] != a[15]);
      end
      4'd4: begin
        c = b - a;
        carry = (a > b);
        flag = (b[15] != a[15]) && (c[15] != b[15]);
      end
      default: begin
        c = a ^ {b[7:0], b[15:8]} ^ {12'h000, op};
        carry = ^a;
        flag = ^b;
        low = (a < b);
      end
    endcase
    return {c[15], (c == 16'h0000), flag, low, carry, c};
  endfunction

  always @(posedge I_CLK) if (O_ALU_ENABLE) {aluSt, aluC} <= aluRef(O_ALU_OPCODE, O_ALU_A, O_ALU_B);

  function automatic int modelGrant(input logic [1:0] mask);
    if (mask == 2'b11) begin
`ifdef CR16_ALU_ARB_FIXED_PRIORITY_EN
      return 0;
`else
      return 1 - lastGrant;
`endif
    end
    return mask[1] ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rspValid"}, 32'(O_RSP_VALID), 0);
    checkOutput({tag, "_rspC"}, 32'(O_RSP_C), 0);
    checkOutput({tag, "_rspStatus"}, 32'(O_RSP_STATUS), 0);
    checkOutput({tag, "_psr"}, 32'(O_PSR), 0);
    checkOutput({tag, "_busy"}, 32'(O_BUSY), 0);
    checkOutput({tag, "_aluEnable"}, 32'(O_ALU_ENABLE), 0);
    checkOutput({tag, "_aluOpcode"}, 32'(O_ALU_OPCODE), 0);
    checkOutput({tag, "_aluA"}, 32'(O_ALU_A), 0);
    checkOutput({tag, "_aluB"}, 32'(O_ALU_B), 0);
  endtask

  // Runs one complete transaction from a negedge in IDLE to the negedge after the handshake.
  task automatic applyStimulus(input logic [1:0] mask, input logic [3:0] op0, input logic [3:0] op1,
                               input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1, input int stall,
                               output int grant, output logic [15:0] gotC,
                               output logic [4:0] gotSt, output logic [4:0] gotPsr);
    int eg, k, lat, enCount;
    logic [3:0] opG;
    logic [15:0] expC;
    logic [4:0] expSt, expPsr;
    logic [1:0] expOneHot;
    eg = modelGrant(mask);
    opG = (eg == 1) ? op1 : op0;
    {expSt, expC} = (opG == 4'hF) ? 21'h0 :
                    aluRef(opG, (eg == 1) ? a1 : a0, (eg == 1) ? b1 : b0);
    expPsr = (opG == 4'hF) ? modelPsr : expSt;
    expOneHot = (eg == 1) ? 2'b10 : 2'b01;
    I_REQ_VALID = mask;
    I_REQ_OPCODE = {op1, op0};
    I_REQ_A = {a1, a0};
    I_REQ_B = {b1, b0};
    grant = -1;
    gotC = '0; gotSt = '0; gotPsr = '0;
    #1;
    k = 0;
    while (!(|(O_REQ_READY & I_REQ_VALID)) && k < 20) begin
      @(posedge I_CLK); @(negedge I_CLK); k++;
    end
    checkOutput("reqReady", 32'(O_REQ_READY), 32'(expOneHot));
    if (k >= 20) begin
      checkOutput("acceptTimeout", 32'(k), 0);
      I_REQ_VALID = '0;
      return;
    end
    grant = O_REQ_READY[1] ? 1 : 0;
    @(posedge I_CLK); @(negedge I_CLK);
    lat = 0;
    enCount = int'(O_ALU_ENABLE);
    while (O_RSP_VALID == 2'b00 && lat < 8) begin
      @(posedge I_CLK); @(negedge I_CLK);
      lat++;
      enCount += int'(O_ALU_ENABLE);
    end
    checkOutput("rspLatency", 32'(lat), (opG == 4'hF) ? 0 : 2);
    checkOutput("aluEnablePulses", 32'(enCount), (opG == 4'hF) ? 0 : 1);
    checkOutput("rspValid", 32'(O_RSP_VALID), 32'(expOneHot));
    checkOutput("rspC", 32'(O_RSP_C), 32'(expC));
    checkOutput("rspStatus", 32'(O_RSP_STATUS), 32'(expSt));
    checkOutput("psr", 32'(O_PSR), 32'(expPsr));
    gotC = O_RSP_C; gotSt = O_RSP_STATUS; gotPsr = O_PSR;
    modelPsr = expPsr;
    for (int s = 0; s < stall; s++) begin
      I_RSP_READY = ~expOneHot;
      @(posedge I_CLK); @(negedge I_CLK);
      checkOutput("stallHold", 32'({O_RSP_VALID, O_RSP_C, O_RSP_STATUS, O_REQ_READY, O_ALU_ENABLE}),
                  32'({expOneHot, expC, expSt, 2'b00, 1'b0}));
    end
    I_RSP_READY = expOneHot;
    @(posedge I_CLK); @(negedge I_CLK);
    checkOutput("afterHandshake", 32'({O_RSP_VALID, O_BUSY}), 0);
    I_RSP_READY = '0;
    lastGrant = eg;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          stall;
    logic [15:0] expC;
    logic [4:0]  expSt;
    logic [4:0]  expPsr;
  } vec_t;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[4];
    int expSeq[6];
    int g;
    logic [15:0] c;
    logic [4:0] st, psr;
    logic seen;

    vecs[0] = '{2'b01, 4'd0,  16'h7FFF, 16'h0001, 5, 16'h8000, 5'b10100, 5'b10100};
    vecs[1] = '{2'b10, 4'd1,  16'hFFFF, 16'h0001, 0, 16'h0000, 5'b01001, 5'b01001};
    vecs[2] = '{2'b10, 4'd15, 16'h1234, 16'h5678, 1, 16'h0000, 5'b00000, 5'b01001};
    vecs[3] = '{2'b01, 4'd4,  16'h0003, 16'h0005, 0, 16'h0002, 5'b00000, 5'b00000};
`ifdef CR16_ALU_ARB_FIXED_PRIORITY_EN
    expSeq = '{0, 0, 0, 0, 0, 0};
`else
    expSeq = '{0, 1, 0, 1, 0, 1};
`endif

    $display("[TB] reset");
    repeat (2) @(posedge I_CLK);
    @(negedge I_CLK);
    checkAllZero("reset");
    I_REQ_VALID = 2'b10;
    #1 checkOutput("resetReadyReq1", 32'(O_REQ_READY), 32'(2'b10));
    I_REQ_VALID = 2'b00;
    I_NRESET = 1'b1;
    @(negedge I_CLK);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      if (vecs[i].mask[1])
        applyStimulus(vecs[i].mask, 4'd2, vecs[i].op, ~vecs[i].a, ~vecs[i].b, vecs[i].a, vecs[i].b,
                      vecs[i].stall, g, c, st, psr);
      else
        applyStimulus(vecs[i].mask, vecs[i].op, 4'd2, vecs[i].a, vecs[i].b, ~vecs[i].a, ~vecs[i].b,
                      vecs[i].stall, g, c, st, psr);
      checkOutput("vecGrant", 32'(g), vecs[i].mask[1] ? 1 : 0);
      checkOutput("vecC", 32'(c), 32'(vecs[i].expC));
      checkOutput("vecStatus", 32'(st), 32'(vecs[i].expSt));
      checkOutput("vecPsr", 32'(psr), 32'(vecs[i].expPsr));
    end

    $display("[TB] reset during WAIT");
    I_REQ_VALID = 2'b01;
    I_REQ_OPCODE = 8'h20;
    I_REQ_A = {16'h0, 16'h8000};
    I_REQ_B = {16'h0, 16'h8000};
    @(posedge I_CLK); @(negedge I_CLK);
    I_REQ_VALID = 2'b00;
    checkOutput("midIssueEnable", 32'(O_ALU_ENABLE), 1);
    @(posedge I_CLK); @(negedge I_CLK);
    checkOutput("midWaitBusy", 32'({O_BUSY, O_ALU_ENABLE, O_RSP_VALID}), 32'(4'b1000));
    I_NRESET = 1'b0;
    @(posedge I_CLK); @(negedge I_CLK);
    checkAllZero("midReset");
    I_NRESET = 1'b1;
    lastGrant = 1;
    modelPsr = '0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge I_CLK); @(negedge I_CLK);
      if (O_RSP_VALID != 2'b00 || O_BUSY) seen = 1'b1;
    end
    checkOutput("noStaleResponse", 32'(seen), 0);

    $display("[TB] both requesters continuously valid");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 4'(i), 4'(i + 5), 16'(i * 300), 16'h0101, 16'hA5A5, 16'(i), 0, g, c, st, psr);
      checkOutput("continuousGrant", 32'(g), 32'(expSeq[i]));
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 2), g, c, st, psr);
    end
    I_REQ_VALID = 2'b00;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/cr16_alu_arbiter.md
# cr16_alu_arbiter

Shares the single CR16 ALU (`cr16_alu`) between two requesters, e.g. the instruction-execute path and an address/immediate-generation unit. It arbitrates between request ports and sequences the ALU's clocked enable. It captures the result and status, returns them over a valid/ready response handshake, and keeps the processor status register (PSR) copy of the last completed operation. It sits between the requesters and the ALU instance; the ALU connects only to this block.

## Interface

Parameters:
- `P_WIDTH`, default 16: operand/result width; must match the ALU.

Ports:
- `I_CLK`  in  1  clock; all logic on rising edge.
- `I_NRESET`  in  1  reset; one clock; reset is synchronous and active-low.
- `I_REQ_VALID`  in  2  per-requester request valid; bit n = requester n.
- `O_REQ_READY`  out  2  per-requester accept; at most one bit high.
- `I_REQ_OPCODE`  in  8  opcodes; [4n+3:4n] = requester n.
- `I_REQ_A`  in  2*P_WIDTH  operand A; [P_WIDTH*(n+1)-1:P_WIDTH*n].
- `I_REQ_B`  in  2*P_WIDTH  operand B; same packing as `I_REQ_A`.
- `O_RSP_VALID`  out  2  one-hot response valid, addressed to the granted requester.
- `I_RSP_READY`  in  2  per-requester response accept.
- `O_RSP_C`  out  P_WIDTH  result.
- `O_RSP_STATUS`  out  5  status: [0] carry, [1] low, [2] flag, [3] zero, [4] negative.
- `O_PSR`  out  5  status of the last completed operation.
- `O_BUSY`  out  1  high whenever state != IDLE.
- `O_ALU_ENABLE`  out  1  to ALU `I_ENABLE`.
- `O_ALU_OPCODE`  out  4  to ALU `I_OPCODE`.
- `O_ALU_A`, `O_ALU_B`  out  P_WIDTH  to ALU operands.
- `I_ALU_C`  in  P_WIDTH  from ALU `O_C`.
- `I_ALU_STATUS`  in  5  from ALU `O_STATUS`.

## Operation

- FSM states and transitions:
  - IDLE: choose the grant `g` among valid requesters. `O_REQ_READY[g]` is high combinationally, and only while in IDLE. When `I_REQ_VALID[g]` is high, latch the opcode and both operands, record `g`, and go to ISSUE.
  - ISSUE: `O_ALU_ENABLE`=1 for exactly one cycle with the latched operands. Go to WAIT.
  - WAIT: the ALU output now holds the new result. Capture `I_ALU_C` into `O_RSP_C` and `I_ALU_STATUS` into both `O_RSP_STATUS` and `O_PSR`. Go to RESP.
  - RESP: `O_RSP_VALID[g]`=1 until `I_RSP_READY[g]` is high. On that handshake, return to IDLE and update the arbitration pointer.
- Arbitration: round-robin. The pointer favours the requester not granted last. After reset the pointer favours requester 0. A single valid requester always wins.
- Opcode 15 is undefined. It is accepted but bypasses ISSUE and WAIT, going IDLE→RESP. Response is C=0, STATUS=0, and `O_PSR` is unchanged.
- All other opcodes, including unimplemented ones, are forwarded unchanged. The result is whatever the ALU returns.
- `O_ALU_OPCODE`, `O_ALU_A` and `O_ALU_B` hold their latched values outside ISSUE. `O_ALU_ENABLE` is 0 in every state except ISSUE.
- Ignored inputs:
  - `I_REQ_VALID` outside IDLE.
  - `I_RSP_READY` bits other than `g`, and `I_RSP_READY[g]` outside RESP.

## Timing

- Reset (`I_NRESET`=0 at an edge) values after that edge:
  - state IDLE, pointer→requester 0.
  - `O_RSP_VALID`=0, `O_RSP_C`=0, `O_RSP_STATUS`=0, `O_PSR`=0, `O_BUSY`=0, `O_ALU_ENABLE`=0, `O_ALU_OPCODE`=0, `O_ALU_A`=0, `O_ALU_B`=0.
  - `O_REQ_READY` follows IDLE arbitration combinationally.
- Reset mid-operation aborts the operation: no response is issued and the in-flight result is discarded.
- Latency, with accept at edge E0:
  - ISSUE in cycle E0→E1.
  - Capture at E2.
  - `O_RSP_VALID` high from E2.
  - With ready already high, the response handshake is at E3. The next accept can be at E4 at the earliest, so minimum 4 cycles per operation.
- Opcode-15 path: accept at E0, `O_RSP_VALID` high from E0.
- Backpressure: `O_RSP_VALID`, `O_RSP_C` and `O_RSP_STATUS` stay stable while RESP waits; no new grant is made.

## Configuration

- `CR16_ALU_ARB_FIXED_PRIORITY_EN` defined: fixed priority. Requester 0 always wins when valid, and the pointer is unused.
- Macro undefined (default): round-robin as above.

## Test plan

- Requester 0 sends ADD (0) with A=0x7FFF, B=0x0001 → `O_RSP_C`=0x8000, `O_RSP_STATUS`=5'b10100, `O_PSR`=5'b10100; `O_RSP_VALID[0]` rises exactly 2 cycles after the accept edge.
- Requester 1 sends ADDU (1) with A=0xFFFF, B=0x0001 → C=0x0000, STATUS=5'b01001; only `O_RSP_VALID[1]` is asserted.
- SUB (4) with A=0x0003, B=0x0005 → C=0x0002, STATUS=5'b00000. Opcode 15 → C=0, STATUS=0, no `O_ALU_ENABLE` pulse, `O_PSR` unchanged.
- Both requesters continuously valid for 6 operations → grants 0,1,0,1,0,1. With `CR16_ALU_ARB_FIXED_PRIORITY_EN` → 0,0,0,0,0,0.
- Hold `I_RSP_READY` low for 5 cycles in RESP → response held stable, `O_REQ_READY`=0, `O_ALU_ENABLE`=0 throughout; completes on the first ready cycle.
- Assert `I_NRESET`=0 during WAIT → after the edge all outputs are 0 and state is IDLE; no response is issued; the next request completes normally.
